pll_lock_sequencer: RTL

Reset and lock sequencer for the board PLL. It runs in the `refclk` domain. It pulses the PLL reset and waits for `locked`, qualifying it as stable before releasing the system reset. It re-sequences on lock loss or a host request and enters a FAIL state after repeated lock timeouts.

---
 rtl/pll_lock_sequencer_if.sv | 47 ++++
 rtl/pll_lock_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if
//   Groups the board-facing signals of the PLL lock sequencer.
//   master : the sequencer. It takes the PLL lock and relock request and
//            drives the PLL reset, system reset, status flags and counts.
//   slave  : the environment. It drives the lock and relock inputs and
//            observes everything else.
//   Signals:
//     pll_locked      - raw asynchronous PLL lock indication
//     force_relock    - single-cycle synchronous restart request
//     pll_rst         - PLL reset
//     sys_rst         - system reset request to downstream domains
//     ready           - sequencer in RUN
//     fail            - sequencer in FAIL
//     attempt_count   - lock timeouts in the current sequence
//     lock_loss_count - lock drops seen while running (saturating)
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] attempt_count;
  logic [7:0] lock_loss_count;

  modport master (
    input  pll_locked,
    input  force_relock,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail,
    output attempt_count,
    output lock_loss_count
  );

  modport slave (
    output pll_locked,
    output force_relock,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail,
    input  attempt_count,
    input  lock_loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Reset and lock sequencer for the board PLL, clocked by refclk. It pulses
//   the PLL reset, waits for a synchronized lock, requires the lock to stay
//   up for a qualification window and then releases the system reset. A lock
//   drop while running or a host relock request restarts the sequence;
//   repeated lock timeouts park the block in FAIL with the PLL held in reset.
//   Ports:
//     refclk - sole clock
//     rst    - asynchronous active-high reset of every register
//     bus    - master side of pll_lock_sequencer_if (lock/relock in, resets,
//              status flags and counts out; all outputs come from flops)
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 240000,
  parameter int unsigned MAX_ATTEMPTS        = 3,
  parameter int unsigned CNT_WIDTH           = 18
) (
  input logic                  refclk,
  input logic                  rst,
  pll_lock_sequencer_if.master bus
);

  // One-hot state encoding; any other code is treated as illegal.
  typedef enum logic [4:0] {
    S_RESET_PLL = 5'b00001,
    S_WAIT_LOCK = 5'b00010,
    S_STABLE    = 5'b00100,
    S_RUN       = 5'b01000,
    S_FAIL      = 5'b10000
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(32'd1);
  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_PULSE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [1:0]           ATTEMPT_MAX  = 2'(MAX_ATTEMPTS);

  // Attempt counter never goes past the attempt limit.
  function automatic logic [1:0] sat_inc_attempt(input logic [1:0] v);
    logic [1:0] r;
    if (v == ATTEMPT_MAX) begin
      r = v;
    end else begin
      r = v + 2'd1;
    end
    return r;
  endfunction

  // Lock-loss counter sticks at all-ones.
  function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             attempt_q, attempt_d;
  logic [7:0]             loss_q, loss_d;
  logic                   lock_meta_q, lock_meta_d;
  logic                   lock_sync_q, lock_sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   lock_s;
  logic [1:0]             attempt_inc_s;

  assign lock_s = lock_sync_q;

  // Next-state, counter and output decode for the sequencer.
  always_comb begin
    lock_meta_d   = bus.pll_locked;
    lock_sync_d   = lock_meta_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    attempt_d     = attempt_q;
    loss_d        = loss_q;
    attempt_inc_s = sat_inc_attempt(attempt_q);

    // A relock request overrides whatever the current state would do,
    // including the lock-loss count update in RUN.
    if (bus.force_relock) begin
      state_d   = S_RESET_PLL;
      cnt_d     = CNT_ZERO;
      attempt_d = 2'b00;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_d = attempt_inc_s;
            cnt_d     = CNT_ZERO;
            if (attempt_inc_s == ATTEMPT_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABLE: begin
          // A glitch sends us back to WAIT_LOCK with a fresh timeout; the
          // attempt count is left alone since no timeout occurred.
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == STABLE_LAST) begin
            state_d   = S_RUN;
            cnt_d     = CNT_ZERO;
            attempt_d = 2'b00;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_RESET_PLL;
            cnt_d   = CNT_ZERO;
            loss_d  = sat_inc_loss(loss_q);
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        S_FAIL: begin
          cnt_d = CNT_ZERO;
        end
        default: begin
          // Illegal code: restart the sequence cleanly.
          state_d = S_RESET_PLL;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register together
    // with the state and never glitch.
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // All sequencer registers, including the lock synchronizer.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= CNT_ZERO;
      attempt_q   <= 2'b00;
      loss_q      <= 8'h00;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      attempt_q   <= attempt_d;
      loss_q      <= loss_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fail            = fail_q;
  assign bus.attempt_count   = attempt_q;
  assign bus.lock_loss_count = loss_q;

endmodule
